// File: rtl/calc_pkg.sv
// Shared op codes, FSM state type and BCD sizing for the sequential calculator.
package calc_pkg;

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4;
  localparam logic [2:0] OP_CLR = 3'd5;

  localparam int unsigned BCD_W = 4;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDivInt,
    StDivFrac,
    StFin
  } state_e;

endpackage

// File: rtl/calc_divider.sv
// Restoring divider: WIDTH integer quotient bits (MSB first), then FRAC_DIGITS
// truncated BCD fraction digits, each found by a 4-step compare against b<<3..b.
module calc_divider
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned FRAC_DIGITS = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [WIDTH-1:0]               a,
  input  logic [WIDTH-1:0]               b,
  output logic                           int_done,
  output logic                           done,
  output logic [WIDTH-1:0]               quotient,
  output logic [BCD_W*FRAC_DIGITS-1:0]   frac
);

  localparam int unsigned Total = WIDTH + BCD_W * FRAC_DIGITS;
  localparam int unsigned CntW  = $clog2(Total + 1);
  localparam int unsigned RemW  = WIDTH + 4;
  localparam int unsigned FracW = BCD_W * FRAC_DIGITS;
  localparam logic [CntW-1:0] WCnt    = CntW'(WIDTH);
  localparam logic [CntW-1:0] IntLast = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] AllLast = CntW'(Total - 1);

  logic             run_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] dvd_q, dsr_q, quot_q;
  logic [RemW-1:0]  rem_q;
  logic [2:0]       dig_q;
  logic [FracW-1:0] frac_q;

  logic             in_frac, ge;
  logic [1:0]       step;
  logic [RemW-1:0]  base10, work, cmp, diff;
  logic [3:0]       new_digit;

  // One restoring step: integer phase shifts in the next dividend bit, fraction
  // phase scales the remainder by 10 on the first step of each digit.
  always_comb begin
    step      = cnt_q[1:0] - WCnt[1:0];
    in_frac   = (cnt_q >= WCnt);
    base10    = (rem_q << 3) + (rem_q << 1);
    if (in_frac) begin
      work = (step == 2'd0) ? base10 : rem_q;
      cmp  = {4'b0000, dsr_q} << (2'd3 - step);
    end else begin
      work = {3'b000, rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
      cmp  = {4'b0000, dsr_q};
    end
    ge        = (work >= cmp);
    diff      = work - cmp;
    new_digit = {dig_q, ge};
  end

  assign int_done = run_q && (cnt_q == IntLast);
  assign done     = run_q && (cnt_q == AllLast);
  assign quotient = quot_q;
  assign frac     = frac_q;

  // Datapath registers; start reloads everything so stale results never leak.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      dvd_q  <= '0;
      dsr_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dig_q  <= '0;
      frac_q <= '0;
    end else if (start) begin
      run_q  <= 1'b1;
      cnt_q  <= '0;
      dvd_q  <= a;
      dsr_q  <= b;
      quot_q <= '0;
      rem_q  <= '0;
      dig_q  <= '0;
      frac_q <= '0;
    end else if (run_q) begin
      cnt_q <= cnt_q + 1'b1;
      if (done) run_q <= 1'b0;
      dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
      rem_q <= ge ? diff : work;
      if (!in_frac) begin
        quot_q <= {quot_q[WIDTH-2:0], ge};
      end else begin
        dig_q <= new_digit[2:0];
        if (step == 2'd3) frac_q <= FracW'({frac_q, new_digit});
      end
    end
  end

endmodule

// File: rtl/seq_calc_core.sv
// Clocked calculator core: add/sub/clear in one cycle, shift-add multiply,
// restoring divide with BCD fraction, under a start/busy/done handshake.
module seq_calc_core
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned FRAC_DIGITS = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [2:0]                     op,
  input  logic [WIDTH-1:0]               a,
  input  logic [WIDTH-1:0]               b,
  output logic                           busy,
  output logic                           done,
  output logic [2*WIDTH-1:0]             result,
  output logic [BCD_W*FRAC_DIGITS-1:0]   frac,
  output logic                           neg,
  output logic                           err
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] MulLast = CntW'(WIDTH - 1);

  state_e state_q, state_d;

  logic [2*WIDTH-1:0] result_q, mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CntW-1:0]    cnt_q;
  logic               neg_q, err_q, div_sel_q;

  logic                         accept, div_start, div_int_done, div_done;
  logic [WIDTH-1:0]             div_quot;
  logic [BCD_W*FRAC_DIGITS-1:0] div_frac;

  assign accept    = (state_q == StIdle) && start;
  assign div_start = accept && (op == OP_DIV) && (b != '0);

  calc_divider #(
    .WIDTH       (WIDTH),
    .FRAC_DIGITS (FRAC_DIGITS)
  ) u_divider (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .a        (a),
    .b        (b),
    .int_done (div_int_done),
    .done     (div_done),
    .quotient (div_quot),
    .frac     (div_frac)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic; single-cycle ops and divide-by-zero go straight to FIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (op == OP_MUL)  state_d = StMul;
          else if (div_start) state_d = StDivInt;
          else               state_d = StFin;
        end
      end
      StMul:     if (cnt_q == MulLast) state_d = StFin;
      StDivInt:  if (div_int_done)     state_d = StDivFrac;
      StDivFrac: if (div_done)         state_d = StFin;
      StFin:     state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Result registers and shift-add multiplier; result_q doubles as the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q  <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      err_q     <= 1'b0;
      div_sel_q <= 1'b0;
    end else if (accept) begin
      result_q  <= '0;
      neg_q     <= 1'b0;
      err_q     <= 1'b0;
      div_sel_q <= div_start;
      cnt_q     <= '0;
      case (op)
        OP_ADD: result_q <= {{(WIDTH-1){1'b0}}, {1'b0, a} + {1'b0, b}};
        OP_SUB: begin
          result_q <= {{WIDTH{1'b0}}, a - b};
          neg_q    <= (a < b);
        end
        OP_MUL: begin
          mcand_q  <= {{WIDTH{1'b0}}, a};
          mplier_q <= b;
        end
        OP_DIV: err_q <= (b == '0);
        OP_CLR: ;
        default: err_q <= 1'b1;
      endcase
    end else if (state_q == StMul) begin
      if (mplier_q[0]) result_q <= result_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  assign busy   = (state_q == StMul) || (state_q == StDivInt) || (state_q == StDivFrac);
  assign done   = (state_q == StFin);
  assign result = div_sel_q ? {{WIDTH{1'b0}}, div_quot} : result_q;
  assign frac   = div_sel_q ? div_frac : '0;
  assign neg    = neg_q;
  assign err    = err_q;

endmodule

// File: doc/seq_calc_core.md
Name: seq_calc_core

Overview:
Parametrised, clocked successor to the 4-bit combinational calculator. It performs add, subtract, multiply and divide on WIDTH-bit unsigned operands under a start/busy/done handshake. Multiply is iterative shift-add. Divide is iterative restoring and also produces FRAC_DIGITS truncated decimal fraction digits in BCD. It sits between the keypad/operand registers and the display/BCD formatting logic of the 16-bit calculator.

Parameters:
WIDTH, 16, operand width in bits (>=4)
FRAC_DIGITS, 2, number of BCD fraction digits produced by divide (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
op  in  3  1=add 2=sub 3=mul 4=div 5=clear; 0,6,7 invalid
a  in  WIDTH  operand 1 (dividend)
b  in  WIDTH  operand 2 (divisor)
busy  out  1  high while a multi-cycle op runs
done  out  1  one-cycle pulse when results become valid
result  out  2*WIDTH  integer result, zero-extended
frac  out  4*FRAC_DIGITS  BCD fraction digits, first digit after the point in MSBs
neg  out  1  sub only: a<b
err  out  1  divide by zero or invalid op

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset: state IDLE; busy, done, result, frac, neg, err all 0. rst wins over start in the same cycle. rst mid-operation abandons the operation: no done pulse, and outputs are zero on the next edge.
- At the start edge, a, b and op are captured into internal registers. Input changes while busy are ignored. start while busy or done is ignored, with no queuing.
- States: IDLE, MUL, DIV_INT, DIV_FRAC, FIN. Single-cycle ops go IDLE -> FIN.
- FIN lasts one cycle with done=1 and busy=0, then returns to IDLE. Outputs hold until the next accepted start.
- A new start is accepted the cycle after done.
- On every accepted start, result, frac, neg and err are cleared, except where the op writes them.
- add: result = a+b, WIDTH+1 bits valid, carry at bit WIDTH. done 1 cycle after the start edge. busy stays 0.
- sub: result[WIDTH-1:0] = (a-b) mod 2^WIDTH, upper bits 0; neg = (a<b). Latency 1.
- clear (op 5): all outputs 0, err 0. Latency 1.
- invalid op: err=1, result 0. Latency 1.
- mul: WIDTH iterations, one shift-add per cycle, LSB first. Full 2*WIDTH-bit product, no overflow possible.
  - busy high for exactly WIDTH cycles.
  - done WIDTH+1 cycles after the start edge.
- div with b=0: err=1, result=0, frac=0. Latency 1. busy stays 0.
- div with b!=0, integer phase (DIV_INT): WIDTH-cycle restoring division, one quotient bit per cycle, MSB first.
  - result = a/b, zero-extended.
  - The remainder rem < b is kept internally.
- div fraction phase (DIV_FRAC): for each fraction digit k=1..FRAC_DIGITS:
  - t = rem*10, WIDTH+4 bits.
  - The 4-bit digit d = t/b is found by 4-cycle restoring compare against b<<3, b<<2, b<<1, b.
  - The new rem is t - d*b.
  - Each digit takes 4 cycles, so the phase takes 4*FRAC_DIGITS cycles.
  - Digits are truncated, never rounded. d is always <=9.
- div timing: busy high for WIDTH + 4*FRAC_DIGITS cycles. done at WIDTH + 4*FRAC_DIGITS + 1 cycles after the start edge.
- Boundaries:
  - a=0: all ops normal; div gives 0 with frac 0.
  - a<b on div: result 0, fraction digits only.
  - Max operands: add carry set; mul yields 0xFFFE0001 at WIDTH=16.

Decomposition:
- calc_pkg holds:
  - op codes OP_ADD=1, OP_SUB=2, OP_MUL=3, OP_DIV=4, OP_CLR=5
  - state enum
  - BCD_W=4
- One natural sub-module, calc_divider, owns the DIV_INT/DIV_FRAC datapath:
  - start/done interface
  - quotient, remainder and digit registers
- The top level keeps the FSM, add/sub and the shift-add multiplier.

Test Plan:
- add a=0xFFFF b=0x0001 -> done 1 cycle after start, result=0x10000, busy never high.
- sub a=3 b=5 -> result=0x0000FFFE, neg=1, err=0; then sub a=5 b=3 -> result=2, neg=0.
- mul a=0xFFFF b=0xFFFF -> busy 16 cycles, done at cycle 17, result=0xFFFE0001; a and b toggled while busy have no effect.
- div a=7 b=3 -> done at cycle 25, result=2, frac=0x33; div a=10 b=4 -> result=2, frac=0x50; div a=1 b=7 -> result=0, frac=0x14.
- div a=5 b=0 -> done 1 cycle, err=1, result=0, frac=0; op=6 -> err=1; op=5 afterwards -> all outputs 0.
- start div a=100 b=7, assert rst at cycle 10 -> next edge busy=0, outputs 0, no done; start pulsed mid-mul -> ignored, single done only.
